// File: rtl/ps2_game_pkg.sv
// ps2_game_pkg
//   Shared codes and encodings for the PS/2 game control mapper.
//   Contents:
//     MOVE_*            3-bit move codes driven on game_controls[5p+2:5p]
//     ATK_*             2-bit attack codes driven on game_controls[5p+4:5p+3]
//     RELEASE_PREFIX    scan-code byte that marks a key release
//     SLOT_*            index of each key slot inside one player's KEYMAP entry
//     atk_state_e       pulse-mode attack FSM states
//     dir_move_code()   direction slot index -> move code
package ps2_game_pkg;

  localparam logic [2:0] MOVE_NONE  = 3'b000;
  localparam logic [2:0] MOVE_UP    = 3'b001;
  localparam logic [2:0] MOVE_LEFT  = 3'b010;
  localparam logic [2:0] MOVE_DOWN  = 3'b011;
  localparam logic [2:0] MOVE_RIGHT = 3'b100;

  localparam logic [1:0] ATK_NONE = 2'b00;
  localparam logic [1:0] ATK0     = 2'b01;
  localparam logic [1:0] ATK1     = 2'b10;

  localparam logic [7:0] RELEASE_PREFIX = 8'hF0;

  // Slot order within a player's 48-bit KEYMAP entry, LSB first.
  localparam int SLOT_UP    = 0;
  localparam int SLOT_LEFT  = 1;
  localparam int SLOT_DOWN  = 2;
  localparam int SLOT_RIGHT = 3;
  localparam int SLOT_ATK0  = 4;
  localparam int SLOT_ATK1  = 5;
  localparam int NUM_SLOTS  = 6;
  localparam int NUM_DIRS   = 4;

  typedef enum logic [1:0] {
    ATK_IDLE  = 2'd0,
    ATK_PULSE = 2'd1,
    ATK_COOL  = 2'd2
  } atk_state_e;

  function automatic logic [2:0] dir_move_code(input int slot);
    case (slot)
      SLOT_UP:    return MOVE_UP;
      SLOT_LEFT:  return MOVE_LEFT;
      SLOT_DOWN:  return MOVE_DOWN;
      SLOT_RIGHT: return MOVE_RIGHT;
      default:    return MOVE_NONE;
    endcase
  endfunction

endpackage

// File: rtl/ps2_player_slot.sv
// ps2_player_slot
//   One player's key state: held flags for its six mapped keys, most-recently
//   pressed ranking of the four direction keys, the attack generator (level or
//   pulse with cooldown) and the registered 5-bit control word.
//   Ports:
//     clk, reset       clock, synchronous active-high reset
//     ev_valid_i       decoded key event this cycle (bare prefix already removed)
//     ev_release_i     event is a release (else a press)
//     ev_code_i        scan code of the event
//     controls_o       registered {attack[1:0], move[2:0]}
//     held_any_o       any of this player's keys is currently held
module ps2_player_slot
  import ps2_game_pkg::*;
#(
  parameter logic [47:0] KEYMAP       = 48'h0,
  parameter int          ATTACK_MODE  = 0,
  parameter int          ATTACK_PULSE = 4,
  parameter int          COOLDOWN     = 16
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       ev_valid_i,
  input  logic       ev_release_i,
  input  logic [7:0] ev_code_i,
  output logic [4:0] controls_o,
  output logic       held_any_o
);

  // Counter loads with N-1 and runs down to 0, so it only has to hold N-1.
  localparam int CNT_MAX = (ATTACK_PULSE > COOLDOWN) ? ATTACK_PULSE : COOLDOWN;
  localparam int CW      = (CNT_MAX < 2) ? 1 : $clog2(CNT_MAX);
  localparam logic [CW-1:0] PULSE_LOAD = CW'(ATTACK_PULSE - 1);
  localparam logic [CW-1:0] COOL_LOAD  = (COOLDOWN > 0) ? CW'(COOLDOWN - 1) : '0;

  logic [NUM_SLOTS-1:0]     match, pressed, released;
  logic [NUM_SLOTS-1:0]     held_q, held_d;
  logic [NUM_DIRS-1:0][1:0] rank_q, rank_d;
  atk_state_e               state_q, state_d;
  logic [CW-1:0]            cnt_q, cnt_d;
  logic [1:0]               code_q, code_d;
  logic [4:0]               controls_q, controls_d;

  // A press only counts on a not-held key; a typematic repeat is invisible.
  always_comb begin
    for (int s = 0; s < NUM_SLOTS; s++) begin
      match[s] = ev_valid_i && (ev_code_i == KEYMAP[s*8 +: 8]);
    end
    pressed  = match & ~held_q & {NUM_SLOTS{~ev_release_i}};
    released = match &  held_q & {NUM_SLOTS{ ev_release_i}};
    held_d   = (held_q | pressed) & ~released;
  end

  // Recency: a new press goes to rank 0 and pushes every held direction back;
  // a release pulls up every held direction that was ranked behind it.
  // NOTE: every combinational output is given a default before any branch so
  // no path leaves it unassigned, which would otherwise infer a latch.
  always_comb begin
    rank_d = rank_q;
    for (int d = 0; d < NUM_DIRS; d++) begin
      if (pressed[d] || released[d]) begin
        rank_d[d] = 2'd0;
      end else if (held_q[d]) begin
        if (|pressed[NUM_DIRS-1:0]) begin
          if (rank_q[d] != 2'd3) rank_d[d] = rank_q[d] + 2'd1;
        end else begin
          for (int j = 0; j < NUM_DIRS; j++) begin
            if (released[j] && (rank_q[j] < rank_q[d])) rank_d[d] = rank_d[d] - 2'd1;
          end
        end
      end
    end
  end

  // Pulse-mode attack FSM; in level mode it never leaves IDLE.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    code_d  = code_q;
    unique case (state_q)
      ATK_IDLE: begin
        if ((ATTACK_MODE != 0) && (pressed[SLOT_ATK0] || pressed[SLOT_ATK1])) begin
          state_d = ATK_PULSE;
          cnt_d   = PULSE_LOAD;
          code_d  = pressed[SLOT_ATK0] ? ATK0 : ATK1;
        end
      end
      ATK_PULSE: begin
        if (cnt_q != '0) begin
          cnt_d = cnt_q - CW'(1);
        end else if (COOLDOWN == 0) begin
          state_d = ATK_IDLE;
        end else begin
          state_d = ATK_COOL;
          cnt_d   = COOL_LOAD;
        end
      end
      ATK_COOL: begin
        if (cnt_q != '0) cnt_d = cnt_q - CW'(1);
        else             state_d = ATK_IDLE;
      end
      default: state_d = ATK_IDLE;
    endcase
  end

  // Output word computed from registered state, so it lands one edge after
  // the event that changed that state.
  always_comb begin
    controls_d = {ATK_NONE, MOVE_NONE};
    for (int d = 0; d < NUM_DIRS; d++) begin
      if (held_q[d] && (rank_q[d] == 2'd0)) controls_d[2:0] = dir_move_code(d);
    end
    if (ATTACK_MODE == 0) begin
      if      (held_q[SLOT_ATK0]) controls_d[4:3] = ATK0;
      else if (held_q[SLOT_ATK1]) controls_d[4:3] = ATK1;
    end else if (state_q == ATK_PULSE) begin
      controls_d[4:3] = code_q;
    end
  end

  // NOTE: state registers use non-blocking assignments so every register
  // samples the pre-edge values regardless of statement order.
  // NOTE: the rank array is small state that feeds the output directly, so
  // unlike a RAM it is cleared on reset rather than left undefined.
  always_ff @(posedge clk) begin
    if (reset) begin
      held_q     <= '0;
      rank_q     <= '0;
      state_q    <= ATK_IDLE;
      cnt_q      <= '0;
      code_q     <= ATK_NONE;
      controls_q <= '0;
    end else begin
      held_q     <= held_d;
      rank_q     <= rank_d;
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      code_q     <= code_d;
      controls_q <= controls_d;
    end
  end

  assign controls_o = controls_q;
  assign held_any_o = |held_q;

endmodule

// File: rtl/ps2_game_mapper.sv
// ps2_game_mapper
//   Maps decoded PS/2 scan-code events onto per-player move/attack codes.
//   Ports:
//     clk            system clock
//     reset          synchronous, active-high reset
//     keycode_in     [15:8]==F0 -> release of [7:0], otherwise press of [7:0]
//     key_valid      one-cycle strobe qualifying keycode_in
//     game_controls  player p at [5p+4:5p] = {attack[1:0], move[2:0]}
//     any_held       registered: some mapped key of some player is held
module ps2_game_mapper
  import ps2_game_pkg::*;
#(
  parameter int                        NUM_PLAYERS  = 2,
  parameter logic [NUM_PLAYERS*48-1:0] KEYMAP       = 96'h5D5B74736B75_2924231B1C1D,
  parameter int                        ATTACK_MODE  = 0,
  parameter int                        ATTACK_PULSE = 4,
  parameter int                        COOLDOWN     = 16
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic [15:0]                keycode_in,
  input  logic                       key_valid,
  output logic [5*NUM_PLAYERS-1:0]   game_controls,
  output logic                       any_held
);

  logic                   ev_valid, ev_release;
  logic [7:0]             ev_code;
  logic [NUM_PLAYERS-1:0] slot_held;
  logic                   any_held_q;

  // A bare F0 byte is only the release prefix on its own; it carries no key.
  assign ev_valid   = key_valid && (keycode_in[7:0] != RELEASE_PREFIX);
  assign ev_release = (keycode_in[15:8] == RELEASE_PREFIX);
  assign ev_code    = keycode_in[7:0];

  for (genvar p = 0; p < NUM_PLAYERS; p++) begin : g_player
    ps2_player_slot #(
      .KEYMAP       (KEYMAP[p*48 +: 48]),
      .ATTACK_MODE  (ATTACK_MODE),
      .ATTACK_PULSE (ATTACK_PULSE),
      .COOLDOWN     (COOLDOWN)
    ) u_slot (
      .clk          (clk),
      .reset        (reset),
      .ev_valid_i   (ev_valid),
      .ev_release_i (ev_release),
      .ev_code_i    (ev_code),
      .controls_o   (game_controls[5*p +: 5]),
      .held_any_o   (slot_held[p])
    );
  end

  // Registered so it aligns with game_controls.
  always_ff @(posedge clk) begin
    if (reset) any_held_q <= 1'b0;
    else       any_held_q <= |slot_held;
  end

  assign any_held = any_held_q;

endmodule

// File: doc/ps2_game_mapper.md
Name: ps2_game_mapper

Overview:
Parametrised successor to the two-player keyboard control mapper. Consumes decoded PS/2 scan-code events (keycode + one-cycle valid strobe) and drives per-player move/attack codes for NUM_PLAYERS players from a parameter-supplied key map. Adds most-recently-pressed direction arbitration across all held keys, a selectable level/pulse attack mode with cooldown, and synchronous reset. Sits between the PS/2 receiver/filter path and the game logic.

Parameters:
NUM_PLAYERS, 2, number of player slots (1..4)
KEYMAP, {P2: 75,6B,73,74,5B,5D ; P1: 1D,1C,1B,23,24,29}, flattened NUM_PLAYERS*6*8 bits; per player, LSB first: up, left, down, right, atk0, atk1 scan codes
ATTACK_MODE, 0, 0 = level (attack code while key held), 1 = pulse
ATTACK_PULSE, 4, pulse-mode attack output length in cycles (>=1)
COOLDOWN, 16, pulse-mode cycles after pulse end during which new attack presses are dropped (0 = none)

Ports:
clk  in  1  system clock
reset  in  1  synchronous, active-high reset
keycode_in  in  16  event code: [15:8]=F0 -> release of [7:0]; otherwise press of [7:0]
key_valid  in  1  one-cycle strobe; keycode_in sampled only when high
game_controls  out  5*NUM_PLAYERS  per player p at [5p+4:5p]: {attack[1:0], move[2:0]}
any_held  out  1  high while any mapped key is held

Behaviour:
- Clock clk; reset synchronous and active-high.
- Reset: all held flags, recency ranks, pulse/cooldown counters cleared; game_controls = 0, any_held = 0 from the edge after reset is sampled high. Keys physically held across reset count as released until re-pressed; a release of a non-held key is ignored.
- Event decode at edge E0 (key_valid=1): low byte F0 (bare prefix) -> ignored. High byte F0 -> release, else press. Every slot whose KEYMAP code equals [7:0] updates (duplicates allowed). Unmapped codes ignored.
- Latency: held/rank state updates at E0; game_controls and any_held reflect it at E1 (registered output).
- Direction recency per player: 2-bit rank per direction key, 0 = newest. Press of non-held key k: rank[k]=0, every held key with rank < old position incremented. Press of already-held key (typematic repeat): no change. Release: key cleared, ranks of remaining held keys compacted.
- move = code of held direction key with rank 0; none held -> 000. Codes: up 001, left 010, down 011, right 100.
- ATTACK_MODE=0: attack = 01 while atk0 held, else 10 while atk1 held, else 00 (atk0 wins).
- ATTACK_MODE=1, per player FSM IDLE -> PULSE -> COOL -> IDLE:
  IDLE: new press (not-held -> held) of atk0/atk1 latches code (01/10), enters PULSE.
  PULSE: attack = latched code for exactly ATTACK_PULSE cycles from E1; then COOL (or IDLE if COOLDOWN=0). Presses ignored; release does not shorten the pulse.
  COOL: attack = 00 for COOLDOWN cycles; presses dropped (not queued); then IDLE. A key still held on entering IDLE does not retrigger.
- Counters saturate/stop; no wrap-around. Reset mid-PULSE/COOL -> IDLE immediately.
- Players independent; one input event per cycle by construction.

Decomposition:
- Package ps2_game_pkg: MOVE_NONE/UP/LEFT/DOWN/RIGHT, ATK_NONE/ATK0/ATK1 codes, RELEASE_PREFIX = 8'hF0, slot indices (UP=0..ATK1=5), attack FSM state encoding.
- Sub-module ps2_player_slot: one player's held flags, recency ranks, attack FSM and 5-bit output; generated NUM_PLAYERS times. Top does decode, any_held OR-reduction, output concatenation.

Test Plan:
- Reset then press 1D (P1 up) at E0 -> game_controls[2:0]=001 at E1, any_held=1; F01D -> 000, any_held=0.
- P1 press 1D, then 23, then release 23 -> move 001, 100, back to 001; release 1D -> 000; repeat press of 1D while held leaves ranks unchanged.
- Mode 0: press 24 and 29 together -> P1 attack 01; release 24 -> 10; P2 press 5D -> [9:8]=10, P1 bits unaffected.
- Mode 1 (PULSE=4, COOLDOWN=16): press 29 -> [4:3]=10 for exactly 4 cycles then 00; press 24 during cooldown -> no pulse; press after cooldown -> 01 pulse.
- Assert reset while P2 holds 75 and mid-pulse -> all outputs 0 next edge; later F075 ignored; press 75 -> [7:5]=001.
- NUM_PLAYERS=3 with custom KEYMAP, unmapped code 0x5A and bare 0x00F0 -> no output change.
